video_mono_mode_sequencer: RTL and testbench
============================================

# video_mono_mode_sequencer

Sequences changes of the 3-bit `gfx_mode` that drives the monochrome/colour converter, so that a new monitor emulation mode never takes effect mid-frame. It latches OSD mode selections and a "cycle mode" hotkey pulse, fades the picture down over whole frames, swaps the mode inside vertical blanking, and fades back up. It sits between the OSD/hotkey logic and the converter. It drives `gfx_mode` and a 4-bit `fade_level`, which the output scaler consumes.

## Interface
- `RESET_MODE`, 3'b000 — mode loaded at reset (colour).
- `FADE_EN`, 1 — 0: swap at the next frame tick with no fade.
- `FRAMES_PER_STEP`, 2 — frame ticks per fade step, range 1..15.

- `clk_vid`  in  1  video clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce_pix`  in  1  pixel enable; all state advances only when it is high.
- `vblank`  in  1  vertical blank from the CRTC.
- `mode_req`  in  3  OSD-selected mode, level.
- `cycle_pulse`  in  1  hotkey; one `ce_pix` cycle wide.
- `gfx_mode`  out  3  mode presented to the converter.
- `fade_level`  out  4  brightness: 15 = full, 0 = black.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Frame tick:** rising edge of `vblank`, sampled on `ce_pix` cycles; it is one `ce_pix` cycle wide.
- **Step counter:** counts frame ticks from 0 to FRAMES_PER_STEP-1. At the terminal count it issues a step and reloads 0.
- **Target register `tgt`:**
  - A change of `mode_req` against its last sampled value loads `tgt` = `mode_req`.
  - Otherwise `cycle_pulse` loads `tgt` = `tgt`+1, wrapping 7→0.
  - If both occur in the same cycle, the `mode_req` change wins.
  - `tgt` may be updated in any state; the latest value is the one used at SWAP.
- **State machine:**
  - IDLE: when `tgt` ≠ `gfx_mode`, go to FADE_OUT. With FADE_EN = 0, go to SWAP instead.
  - FADE_OUT: each step decrements `fade_level`. When the level reaches 0, go to SWAP.
  - SWAP: on the next frame tick, `gfx_mode` ← `tgt`, then go to FADE_IN. The step counter is cleared.
  - FADE_IN: each step increments `fade_level`. When the level reaches 15, go to IDLE.
    - If `tgt` ≠ `gfx_mode` during FADE_IN, go back to FADE_OUT from the current level (no jump).
  - If SWAP finds `tgt` = `gfx_mode`, the mode is left unchanged and FADE_IN still runs.
- **Width rules:**
  - `fade_level` saturates at 0 and at 15 and never wraps.
  - With FADE_EN = 0, `fade_level` stays at 15 permanently.

## Timing
- **Reset values:** `gfx_mode` = RESET_MODE, `fade_level` = 15, `busy` = 0, state IDLE, `tgt` = RESET_MODE, step counter 0. The last-sampled `mode_req` register resets to RESET_MODE.
- **Reset mid-fade:** outputs return to their reset values immediately (asynchronous). After release, the previous `tgt` is lost.
- **Request to `busy`:** a request seen on `ce_pix` cycle N gives `busy` = 1 on cycle N+1.
- **`gfx_mode` update:** changes only in the `ce_pix` cycle that carries the frame tick in SWAP. Therefore it only ever changes within `vblank`.
- **Full transition length:** 15·FRAMES_PER_STEP frames down, plus at most 1 frame waiting in SWAP, plus 15·FRAMES_PER_STEP frames up.
- **Stalls:** when `ce_pix` is low, all registers hold their values.

## Structure
- **Package `video_mono_pkg`:**
  - `mono_mode_t` enum: COLOR = 0, GREEN = 1, AMBER = 2, BW = 3, MYSTERY = 4, RED = 5, FUCHSIA = 6, VIOLET = 7.
  - `seq_state_t` enum: IDLE, FADE_OUT, SWAP, FADE_IN.
  - Constants `FADE_MAX` = 4'd15 and `FADE_MIN` = 4'd0.
- **Sub-module `video_frame_tick`:** `vblank` edge detect plus the FRAMES_PER_STEP step counter. Outputs `frame_tick` and `step`.

## Test plan
- **Reset default:** assert `reset`, hold `mode_req` = 0 → `gfx_mode` = 0, `fade_level` = 15, `busy` = 0; no change over 5 frames.
- **Single change:** FRAMES_PER_STEP = 2, set `mode_req` = 1.
  - `busy` rises 1 `ce_pix` cycle later.
  - `fade_level` falls 15→0 over 30 frames.
  - `gfx_mode` = 1 appears on a frame tick inside `vblank`.
  - `fade_level` returns to 15 after a further 30 frames, then `busy` = 0.
- **Hotkey wrap:** `gfx_mode` = 7, one `cycle_pulse` → final `gfx_mode` = 0.
- **Collision:** `cycle_pulse` and a `mode_req` change 0→3 in the same cycle → final `gfx_mode` = 3.
- **Retarget:**
  - During FADE_OUT at level 8, change `mode_req` to 5 → SWAP loads 5.
  - During FADE_IN at level 6, change `mode_req` to 2 → FADE_OUT resumes from 6; final `gfx_mode` = 2.
- **No fade and reset mid-fade:**
  - FADE_EN = 0: request mode 4 → `gfx_mode` = 4 at the next frame tick, and `fade_level` stays 15 throughout.
  - Reset asserted at `fade_level` = 9 → `gfx_mode` = RESET_MODE and `fade_level` = 15 immediately.

Source files
------------

// File: rtl/video_mono_pkg.sv
// Shared types and constants for the monochrome mode sequencer.
package video_mono_pkg;

    typedef enum logic [2:0] {
        COLOR   = 3'd0,
        GREEN   = 3'd1,
        AMBER   = 3'd2,
        BW      = 3'd3,
        MYSTERY = 3'd4,
        RED     = 3'd5,
        FUCHSIA = 3'd6,
        VIOLET  = 3'd7
    } mono_mode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } seq_state_t;

    localparam logic [3:0] FADE_MAX = 4'd15;
    localparam logic [3:0] FADE_MIN = 4'd0;

endpackage

// File: rtl/video_mono_mode_sequencer_frame_tick.sv
// Frame tick from the vblank rising edge, and a frame counter that issues one fade step
// every FRAMES_PER_STEP ticks.
module video_frame_tick #(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ce_pix,
    input  logic vblank,
    input  logic clear,
    output logic frame_tick,
    output logic step
);

    localparam logic [3:0] LAST_CNT = 4'(FRAMES_PER_STEP - 1);

    logic       vblank_q;
    logic [3:0] cnt;

    assign frame_tick = ce_pix && vblank && !vblank_q;
    assign step       = frame_tick && !clear && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q <= 1'b0;
            cnt      <= 4'd0;
        end else if (ce_pix) begin
            vblank_q <= vblank;
            if (clear) begin
                cnt <= 4'd0;
            end else if (frame_tick) begin
                cnt <= (cnt == LAST_CNT) ? 4'd0 : cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/video_mono_mode_sequencer.sv
// Sequences gfx_mode changes: fade down over whole frames, swap on a vblank tick, fade back up,
// so a new monitor emulation mode never takes effect mid-frame.
module video_mono_mode_sequencer
    import video_mono_pkg::*;
#(
    parameter logic [2:0]  RESET_MODE      = 3'b000,
    parameter bit          FADE_EN         = 1'b1,
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       vblank,
    input  logic [2:0] mode_req,
    input  logic       cycle_pulse,
    output logic [2:0] gfx_mode,
    output logic [3:0] fade_level,
    output logic       busy
);

    seq_state_t state;
    logic [2:0] tgt;
    logic [2:0] req_q;
    logic [2:0] tgt_next;
    logic       frame_tick;
    logic       step;
    logic       cnt_clear;
    logic       retarget;

    // A mode_req change beats a same-cycle hotkey pulse.
    always_comb begin
        tgt_next = tgt;
        if (mode_req != req_q) begin
            tgt_next = mode_req;
        end else if (cycle_pulse) begin
            tgt_next = tgt + 3'd1;
        end
    end

    assign retarget  = (tgt_next != gfx_mode);
    // Holding the counter at 0 while idle makes every fade start on a step boundary.
    assign cnt_clear = (state == IDLE) || ((state == SWAP) && frame_tick);

    video_frame_tick #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_frame_tick (
        .clk       (clk_vid),
        .rst       (reset),
        .ce_pix    (ce_pix),
        .vblank    (vblank),
        .clear     (cnt_clear),
        .frame_tick(frame_tick),
        .step      (step)
    );

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gfx_mode   <= RESET_MODE;
            fade_level <= FADE_MAX;
            busy       <= 1'b0;
            tgt        <= RESET_MODE;
            req_q      <= RESET_MODE;
        end else if (ce_pix) begin
            tgt   <= tgt_next;
            req_q <= mode_req;
            unique case (state)
                IDLE: begin
                    if (retarget) begin
                        busy <= 1'b1;
                        if (FADE_EN) begin
                            state <= FADE_OUT;
                        end else begin
                            state <= SWAP;
                        end
                    end
                end
                FADE_OUT: begin
                    if (fade_level == FADE_MIN) begin
                        state <= SWAP;
                    end else if (step) begin
                        fade_level <= fade_level - 4'd1;
                        if (fade_level == FADE_MIN + 4'd1) begin
                            state <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    if (frame_tick) begin
                        gfx_mode <= tgt_next;
                        if (FADE_EN) begin
                            state <= FADE_IN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                FADE_IN: begin
                    // A new target reverses the fade from wherever the level is now.
                    if (retarget) begin
                        state <= FADE_OUT;
                    end else if (fade_level == FADE_MAX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (step) begin
                        fade_level <= fade_level + 4'd1;
                        if (fade_level == FADE_MAX - 4'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_mono_mode_sequencer.sv
// Directed bench for video_mono_mode_sequencer: a frame-level model of the fade/swap rules is
// checked against two instances (fading and non-fading) every clock, plus literal spot checks.
module tb_video_mono_mode_sequencer;

    localparam int FPS = 2;

    typedef struct packed {
        int level;
        int mode;
        int tgt;
        int last_req;
        int dir;       // -1 fading down, +1 fading up, 0 steady
        bit at_swap;   // waiting for the frame tick that swaps the mode
        int frames;    // frame ticks since the last fade step
        bit vb_prev;
    } mdl_t;

    logic       clk_vid;
    logic       reset;
    logic       ce_pix;
    logic       vblank;
    logic [2:0] mode_a;
    logic       cyc_a;
    logic [2:0] mode_b;
    logic       cyc_b;
    logic [2:0] gfx_a;
    logic [3:0] fade_a;
    logic       busy_a;
    logic [2:0] gfx_b;
    logic [3:0] fade_b;
    logic       busy_b;

    mdl_t ma;
    mdl_t mb;

    int         n_vec = 0;
    int         n_err = 0;
    int         raw = 0;
    int         ticks_total = 0;
    bit         vb_seen = 1'b0;
    bit         last_ce = 1'b0;
    bit         prev_rst = 1'b1;
    logic [2:0] prev_gfx_a = 3'd0;
    logic [2:0] prev_gfx_b = 3'd0;

    video_mono_mode_sequencer #(
        .RESET_MODE     (3'b000),
        .FADE_EN        (1'b1),
        .FRAMES_PER_STEP(FPS)
    ) dut_a (
        .clk_vid    (clk_vid),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .vblank     (vblank),
        .mode_req   (mode_a),
        .cycle_pulse(cyc_a),
        .gfx_mode   (gfx_a),
        .fade_level (fade_a),
        .busy       (busy_a)
    );

    video_mono_mode_sequencer #(
        .RESET_MODE     (3'b000),
        .FADE_EN        (1'b0),
        .FRAMES_PER_STEP(FPS)
    ) dut_b (
        .clk_vid    (clk_vid),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .vblank     (vblank),
        .mode_req   (mode_b),
        .cycle_pulse(cyc_b),
        .gfx_mode   (gfx_b),
        .fade_level (fade_b),
        .busy       (busy_b)
    );

    initial begin
        clk_vid = 1'b0;
        forever #5 clk_vid = ~clk_vid;
    end

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.level    = 15;
        m.mode     = 0;
        m.tgt      = 0;
        m.last_req = 0;
        m.dir      = 0;
        m.at_swap  = 1'b0;
        m.frames   = 0;
        m.vb_prev  = 1'b0;
        return m;
    endfunction

    function automatic bit mdl_busy(mdl_t m);
        return (m.dir != 0) || m.at_swap;
    endfunction

    // One ce_pix cycle of the sequencing rules.
    function automatic mdl_t mdl_next(mdl_t m, bit fade_en, bit vb, int req, bit pulse);
        mdl_t n = m;
        bit   tk;
        bit   stp;
        bit   idle;
        int   ntgt;
        tk = vb && !m.vb_prev;
        n.vb_prev = vb;
        ntgt = m.tgt;
        if (req != m.last_req) ntgt = req;
        else if (pulse) ntgt = (m.tgt + 1) % 8;
        n.tgt = ntgt;
        n.last_req = req;
        idle = (m.dir == 0) && !m.at_swap;
        stp = 1'b0;
        if (idle || (m.at_swap && tk)) begin
            n.frames = 0;
        end else if (tk) begin
            n.frames = m.frames + 1;
            if (n.frames == FPS) begin
                n.frames = 0;
                stp = 1'b1;
            end
        end
        if (idle) begin
            if (ntgt != m.mode) begin
                if (fade_en) n.dir = -1;
                else n.at_swap = 1'b1;
            end
        end else if (m.at_swap) begin
            if (tk) begin
                n.mode = ntgt;
                n.at_swap = 1'b0;
                n.dir = fade_en ? 1 : 0;
            end
        end else if (m.dir < 0) begin
            if (m.level == 0) begin
                n.dir = 0;
                n.at_swap = 1'b1;
            end else if (stp) begin
                n.level = m.level - 1;
                if (n.level == 0) begin
                    n.dir = 0;
                    n.at_swap = 1'b1;
                end
            end
        end else begin
            if (ntgt != m.mode) n.dir = -1;
            else if (m.level == 15) n.dir = 0;
            else if (stp) begin
                n.level = m.level + 1;
                if (n.level == 15) n.dir = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else if (ce_pix) begin
            ma <= mdl_next(ma, 1'b1, vblank, int'(mode_a), cyc_a);
            mb <= mdl_next(mb, 1'b0, vblank, int'(mode_b), cyc_b);
        end
    end

    task automatic check_out(string name, logic [2:0] g, logic [3:0] f, logic b, mdl_t m);
        n_vec++;
        if ({g, f, b} !== {3'(m.mode), 4'(m.level), mdl_busy(m)}) begin
            n_err++;
            $display("FAIL %s @%0t: got gfx=%0d fade=%0d busy=%0b, want gfx=%0d fade=%0d busy=%0b",
                     name, $time, g, f, b, m.mode, m.level, mdl_busy(m));
        end
    endtask

    task automatic check_val(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic compare_cycle();
        check_out("model_a", gfx_a, fade_a, busy_a, ma);
        check_out("model_b", gfx_b, fade_b, busy_b, mb);
        if (!reset && !prev_rst && gfx_a != prev_gfx_a) check_val("swap_in_vblank_a", int'(vblank), 1);
        if (!reset && !prev_rst && gfx_b != prev_gfx_b) check_val("swap_in_vblank_b", int'(vblank), 1);
        if (!reset) check_val("nofade_level_b", int'(fade_b), 15);
        prev_rst   = reset;
        prev_gfx_a = gfx_a;
        prev_gfx_b = gfx_b;
    endtask

    // Advance one clock: count the frame tick the coming edge carries, then drive the
    // next ce_pix/vblank and compare on the falling edge.
    task automatic tick_cyc();
        bit tk;
        tk = !reset && ce_pix && vblank && !vb_seen;
        if (reset) vb_seen = 1'b0;
        else if (ce_pix) vb_seen = vblank;
        last_ce = ce_pix;
        @(posedge clk_vid);
        #2;
        if (tk) ticks_total++;
        raw++;
        ce_pix = (raw % 4) != 3;
        vblank = (raw % 32) >= 24;
        @(negedge clk_vid);
        compare_cycle();
    endtask

    task automatic ce_cyc();
        int n = 0;
        do begin
            tick_cyc();
            n++;
        end while (!last_ce && n < 8);
    endtask

    task automatic wait_ticks(int n);
        int target = ticks_total + n;
        int c = 0;
        while (ticks_total < target && c < 64 * (n + 2)) begin
            tick_cyc();
            c++;
        end
        if (ticks_total < target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ticks: got %0d ticks, want %0d", ticks_total, target);
        end
    endtask

    task automatic wait_idle(string name);
        int c = 0;
        while (busy_a !== 1'b0 && c < 6000) begin
            tick_cyc();
            c++;
        end
        check_val(name, int'(busy_a), 0);
    endtask

    task automatic wait_level(string name, int g, int f);
        int c = 0;
        while (!((g < 0 || int'(gfx_a) == g) && int'(fade_a) == f) && c < 6000) begin
            tick_cyc();
            c++;
        end
        check_val(name, int'(fade_a), f);
    endtask

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        vblank = 1'b0;
        mode_a = 3'd0;
        cyc_a  = 1'b0;
        mode_b = 3'd0;
        cyc_b  = 1'b0;
        repeat (4) tick_cyc();
        reset = 1'b0;

        // Reset default, quiet for 5 frames
        wait_ticks(5);
        check_val("rst_gfx", int'(gfx_a), 0);
        check_val("rst_fade", int'(fade_a), 15);
        check_val("rst_busy", int'(busy_a), 0);

        // Single change to mode 1
        mode_a = 3'd1;
        ce_cyc();
        check_val("busy_rise", int'(busy_a), 1);
        check_val("fade_hold", int'(fade_a), 15);
        wait_ticks(2);
        check_val("first_step", int'(fade_a), 14);
        wait_ticks(28);
        check_val("black", int'(fade_a), 0);
        check_val("pre_swap_gfx", int'(gfx_a), 0);
        wait_ticks(1);
        check_val("swap_gfx", int'(gfx_a), 1);
        wait_ticks(29);
        check_val("up_almost", int'(fade_a), 14);
        check_val("up_busy", int'(busy_a), 1);
        wait_ticks(1);
        check_val("up_full", int'(fade_a), 15);
        check_val("done_busy", int'(busy_a), 0);

        // Hotkey wrap 7 -> 0
        mode_a = 3'd7;
        ce_cyc();
        wait_idle("idle_at_7");
        check_val("gfx_7", int'(gfx_a), 7);
        cyc_a = 1'b1;
        ce_cyc();
        cyc_a = 1'b0;
        check_val("hotkey_busy", int'(busy_a), 1);
        wait_idle("idle_wrap");
        check_val("gfx_wrap", int'(gfx_a), 0);

        // Collision: mode_req 0->3 with a hotkey pulse in the same cycle
        mode_a = 3'd0;
        ce_cyc();
        check_val("no_req_busy", int'(busy_a), 0);
        mode_a = 3'd3;
        cyc_a  = 1'b1;
        ce_cyc();
        cyc_a  = 1'b0;
        wait_idle("idle_collision");
        check_val("gfx_collision", int'(gfx_a), 3);

        // Retarget during fade-out
        mode_a = 3'd1;
        ce_cyc();
        wait_level("reach_8", -1, 8);
        mode_a = 3'd5;
        ce_cyc();
        wait_idle("idle_retarget_out");
        check_val("gfx_retarget_out", int'(gfx_a), 5);

        // Retarget during fade-in
        mode_a = 3'd6;
        ce_cyc();
        wait_level("reach_6_up", 6, 6);
        mode_a = 3'd2;
        ce_cyc();
        check_val("reverse_level", int'(fade_a), 6);
        check_val("reverse_busy", int'(busy_a), 1);
        wait_ticks(4);
        check_val("reverse_down", int'(fade_a), 4);
        wait_idle("idle_retarget_in");
        check_val("gfx_retarget_in", int'(gfx_a), 2);

        // No-fade instance
        mode_b = 3'd4;
        ce_cyc();
        check_val("nf_busy", int'(busy_b), 1);
        check_val("nf_pre_gfx", int'(gfx_b), 0);
        wait_ticks(1);
        check_val("nf_gfx", int'(gfx_b), 4);
        check_val("nf_fade", int'(fade_b), 15);
        check_val("nf_done", int'(busy_b), 0);

        // Reset mid-fade
        mode_a = 3'd1;
        ce_cyc();
        wait_level("reach_9", -1, 9);
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_mid_gfx", int'(gfx_a), 0);
        check_val("rst_mid_fade", int'(fade_a), 15);
        check_val("rst_mid_busy", int'(busy_a), 0);
        check_val("rst_mid_gfx_b", int'(gfx_b), 0);
        mode_a = 3'd0;
        mode_b = 3'd0;
        repeat (3) tick_cyc();
        reset = 1'b0;
        wait_ticks(3);
        check_val("post_rst_busy", int'(busy_a), 0);
        check_val("post_rst_gfx", int'(gfx_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
